// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side blocks: arbiter state encoding,
// default byte width and a constant clog2 helper for index widths.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } arb_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1)
            r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin select: first set bit of req at or above ptr, with wrap.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          any,
    output logic [PW-1:0] idx
);

    int            c;
    logic [PW-1:0] w_c;

    // Walk offsets from the far end so the smallest offset from ptr wins.
    always_comb begin
        any = |req;
        idx = '0;
        c   = 0;
        w_c = '0;
        for (int off = N - 1; off >= 0; off--) begin
            c = int'(ptr) + off;
            if (c >= N)
                c = c - N;
            w_c = PW'(c);
            if (req[w_c])
                idx = w_c;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter feeding the UART TX FIFO write port,
// with a per-grant burst limit and an idle timeout on the owner.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int NUM_REQ      = 4,
    parameter  int DATA_W       = UART_DATA_W,
    parameter  int MAX_BURST    = 16,
    parameter  int IDLE_TIMEOUT = 32,
    localparam int GW           = clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_wr,
    output logic [DATA_W-1:0]         fifo_wr_data,
    output logic [GW-1:0]             grant_id,
    output logic                      busy
);

    arb_state_t r_state, w_state_nxt;
    logic [GW-1:0] r_grant_id, r_rr_ptr;
    logic [7:0]    r_burst_cnt, r_idle_cnt;

    logic [NUM_REQ-1:0][DATA_W-1:0] w_data;
    logic          w_any, w_beat, w_idle_tick, w_release;
    logic [GW-1:0] w_idx, w_ptr_nxt;
    logic [7:0]    w_burst_nxt, w_idle_nxt;

    assign w_data = req_data;

    rr_pick #(.N(NUM_REQ), .PW(GW)) u_pick (
        .req (req_valid),
        .ptr (r_rr_ptr),
        .any (w_any),
        .idx (w_idx)
    );

    assign w_beat      = (r_state == ST_XFER) & req_valid[r_grant_id] & ~fifo_full;
    assign w_idle_tick = (r_state == ST_XFER) & ~req_valid[r_grant_id] & ~fifo_full;
    assign w_burst_nxt = (r_burst_cnt == 8'hFF) ? 8'hFF : r_burst_cnt + 8'd1;
    assign w_idle_nxt  = (r_idle_cnt == 8'hFF) ? 8'hFF : r_idle_cnt + 8'd1;
    assign w_ptr_nxt   = (r_grant_id == GW'(NUM_REQ - 1)) ? '0 : r_grant_id + GW'(1);

    // Last beat, burst exhaustion and idle timeout all collapse into one release.
    assign w_release = (w_beat && (req_last[r_grant_id] || w_burst_nxt == 8'(MAX_BURST)))
                    || (w_idle_tick && w_idle_nxt == 8'(IDLE_TIMEOUT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_any)     w_state_nxt = ST_XFER;
            ST_XFER: if (w_release) w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready    = '0;
        fifo_wr      = 1'b0;
        fifo_wr_data = '0;
        if (r_state == ST_XFER) begin
            req_ready[r_grant_id] = ~fifo_full;
            fifo_wr               = w_beat;
            if (w_beat)
                fifo_wr_data = w_data[r_grant_id];
        end
    end

    assign busy     = (r_state == ST_XFER);
    assign grant_id = r_grant_id;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant_id  <= '0;
            r_rr_ptr    <= '0;
            r_burst_cnt <= '0;
            r_idle_cnt  <= '0;
        end else if (r_state == ST_IDLE) begin
            if (w_any) begin
                r_grant_id  <= w_idx;
                r_burst_cnt <= '0;
                r_idle_cnt  <= '0;
            end
        end else if (w_release) begin
            r_rr_ptr <= w_ptr_nxt;
        end else if (w_beat) begin
            r_burst_cnt <= w_burst_nxt;
            r_idle_cnt  <= '0;
        end else if (w_idle_tick) begin
            r_idle_cnt <= w_idle_nxt;
        end
    end

endmodule
